// File: rtl/input_conditioner_pkg.sv
// Shared constants, repeat-FSM state encoding and counter sizing helper
// for the pushbutton/switch input conditioner.
package input_conditioner_pkg;

    localparam int DEF_N_BTN         = 7;
    localparam int DEF_N_SW          = 6;
    localparam int DEF_TICK_DIV      = 100000;
    localparam int DEF_STABLE_TICKS  = 10;
    localparam int DEF_REPEAT_START  = 500;
    localparam int DEF_REPEAT_PERIOD = 100;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HELD      = 2'd1,
        REPEATING = 2'd2
    } rpt_state_t;

    // Bits needed to hold values 0..max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchronizer, tick-sampled stable counter,
// debounced level and single-cycle rise/fall pulses.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(STABLE_TICKS);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (tick) begin
                if (sync_2 == level) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == CW'(STABLE_TICKS - 1)) begin
                    // this tick is the STABLE_TICKS-th consecutive disagreement
                    level      <= ~level;
                    stable_cnt <= '0;
                    rise       <= ~level;
                    fall       <= level;
                end else begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Input front end: synchronizes and debounces pushbuttons and slide switches,
// producing clean levels, press/release pulses and optional auto-repeat.
//
// state     | meaning
// RELEASED  | button debounced low, no repeat activity
// HELD      | button down, counting ticks toward the first repeat
// REPEATING | button down, issuing a repeat pulse every REPEAT_PERIOD ticks
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_BTN         = DEF_N_BTN,
    parameter int N_SW          = DEF_N_SW,
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int STABLE_TICKS  = DEF_STABLE_TICKS,
    parameter int REPEAT_START  = DEF_REPEAT_START,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_level,
    output logic             sw_changed
);

    localparam int PW = cnt_width(TICK_DIV - 1);
    localparam int HW = cnt_width((REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic          lvl;
        logic          rise;
        logic          fall;
        logic          rep_q;
        logic [HW-1:0] hold_cnt;
        rpt_state_t    state;

        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .raw   (btn_raw[i]),
            .level (lvl),
            .rise  (rise),
            .fall  (fall)
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state    <= RELEASED;
                hold_cnt <= '0;
                rep_q    <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                if (fall) begin
                    state    <= RELEASED;
                    hold_cnt <= '0;
                end else if (rise) begin
                    state    <= HELD;
                    hold_cnt <= '0;
                end else if (tick) begin
                    case (state)
                        HELD: begin
                            // hold_cnt saturates at REPEAT_START while repeat is disabled
                            if (hold_cnt >= HW'(REPEAT_START - 1) && repeat_en[i]) begin
                                rep_q    <= 1'b1;
                                state    <= REPEATING;
                                hold_cnt <= '0;
                            end else if (hold_cnt < HW'(REPEAT_START)) begin
                                hold_cnt <= hold_cnt + HW'(1);
                            end
                        end
                        REPEATING: begin
                            if (!repeat_en[i]) begin
                                state    <= HELD;
                                hold_cnt <= HW'(REPEAT_START);
                            end else if (hold_cnt == HW'(REPEAT_PERIOD - 1)) begin
                                rep_q    <= 1'b1;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + HW'(1);
                            end
                        end
                        default: begin
                            hold_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        // a repeat fired on the tick where the release lands is dropped
        assign btn_level[i]   = lvl;
        assign btn_press[i]   = rise | (rep_q & lvl);
        assign btn_release[i] = fall;
    end

    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;

    for (genvar j = 0; j < N_SW; j++) begin : g_sw
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .raw   (sw_raw[j]),
            .level (sw_level[j]),
            .rise  (sw_rise[j]),
            .fall  (sw_fall[j])
        );
    end

    assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random
// stimulus, all compared cycle by cycle against a tick-level behavioural model.
module tb_input_conditioner;

    localparam int NB = 7;
    localparam int NS = 6;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int RS = 6;
    localparam int RP = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] repeat_en = '0;
    logic [NS-1:0] sw_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic [NS-1:0] sw_level;
    logic          sw_changed;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .N_BTN(NB), .N_SW(NS), .TICK_DIV(TD), .STABLE_TICKS(ST),
        .REPEAT_START(RS), .REPEAT_PERIOD(RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .sw_raw     (sw_raw),
        .repeat_en  (repeat_en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sw_level   (sw_level),
        .sw_changed (sw_changed)
    );

    // Behavioural model: per-tick debounce rules and a "ticks since last pulse" repeat view.
    typedef struct packed {
        logic [2:0]            pcnt;
        logic [NB-1:0]         b_s1, b_s2, b_lvl, b_press, b_rel, b_first;
        logic [NB-1:0][7:0]    b_cnt;
        logic [NB-1:0][15:0]   b_elapsed;
        logic [NS-1:0]         w_s1, w_s2, w_lvl;
        logic [NS-1:0][7:0]    w_cnt;
        logic                  w_chg;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t c, logic [NB-1:0] braw,
                                          logic [NS-1:0] sraw, logic [NB-1:0] ren);
        model_t n = c;
        bit tk = (c.pcnt == 3'(TD - 1));
        n.pcnt    = tk ? 3'd0 : c.pcnt + 3'd1;
        n.b_press = '0;
        n.b_rel   = '0;
        n.w_chg   = 1'b0;
        n.b_s1 = braw;
        n.b_s2 = c.b_s1;
        n.w_s1 = sraw;
        n.w_s2 = c.w_s1;
        if (tk) begin
            for (int i = 0; i < NB; i++) begin
                int cnt = int'(c.b_cnt[i]) + 1;
                int el  = int'(c.b_elapsed[i]);
                if (c.b_s2[i] == c.b_lvl[i]) begin
                    n.b_cnt[i] = 8'd0;
                end else if (cnt >= ST) begin
                    n.b_lvl[i] = ~c.b_lvl[i];
                    n.b_cnt[i] = 8'd0;
                    if (n.b_lvl[i]) begin
                        n.b_press[i] = 1'b1;
                        n.b_first[i] = 1'b1;
                        el = 0;
                    end else begin
                        n.b_rel[i] = 1'b1;
                    end
                end else begin
                    n.b_cnt[i] = 8'(cnt);
                end
                if (c.b_lvl[i] && n.b_lvl[i]) begin
                    if (!ren[i]) begin
                        if (!c.b_first[i]) begin
                            n.b_first[i] = 1'b1;
                            el = RS;
                        end else if (el < 1000) begin
                            el++;
                        end
                    end else begin
                        el++;
                        if (el >= (c.b_first[i] ? RS : RP)) begin
                            n.b_press[i] = 1'b1;
                            n.b_first[i] = 1'b0;
                            el = 0;
                        end
                    end
                end
                n.b_elapsed[i] = 16'(el);
            end
            for (int j = 0; j < NS; j++) begin
                int cnt = int'(c.w_cnt[j]) + 1;
                if (c.w_s2[j] == c.w_lvl[j]) begin
                    n.w_cnt[j] = 8'd0;
                end else if (cnt >= ST) begin
                    n.w_lvl[j] = ~c.w_lvl[j];
                    n.w_cnt[j] = 8'd0;
                end else begin
                    n.w_cnt[j] = 8'(cnt);
                end
            end
            n.w_chg = |(n.w_lvl ^ c.w_lvl);
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= model_next(m, btn_raw, sw_raw, repeat_en);
    end

    logic [3*NB+NS:0] dut_vec, exp_vec;
    assign dut_vec = {btn_level, btn_press, btn_release, sw_level, sw_changed};
    assign exp_vec = {m.b_lvl, m.b_press, m.b_rel, m.w_lvl, m.w_chg};

    task automatic test_reset();
        int pc [NB];
        int swc = 0;
        foreach (pc[i]) pc[i] = 0;
        btn_raw = '1; sw_raw = '1; repeat_en = '0; reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_state got=%h exp=0", dut_vec);
        end
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
            for (int i = 0; i < NB; i++) pc[i] += int'(btn_press[i]);
            swc += int'(sw_changed);
        end
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (pc[i] != 1) begin
                errors++; $display("FAIL reset_press_count ch=%0d got=%0d exp=1", i, pc[i]);
            end
        end
        checks++;
        if (swc != 1) begin
            errors++; $display("FAIL reset_sw_changed_count got=%0d exp=1", swc);
        end
        checks++;
        if ({btn_level, sw_level} !== '1) begin
            errors++; $display("FAIL reset_levels got=%h exp=all ones", {btn_level, sw_level});
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_async_clear got=%h exp=0", dut_vec);
        end
        btn_raw = '0; sw_raw = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_bounce();
        int presses = 0;
        int releases = 0;
        for (int k = 0; k < 40; k++) begin
            btn_raw[0] = ((k / 3) % 2 == 0);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec || btn_level[0] !== 1'b0) begin
                errors++; $display("FAIL bounce_active cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
        end
        btn_raw[0] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL bounce_settle cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
            presses += int'(btn_press[0]);
        end
        checks++;
        if (presses != 1 || btn_level[0] !== 1'b1) begin
            errors++; $display("FAIL bounce_single_press got=%0d lvl=%b exp=1 lvl=1", presses, btn_level[0]);
        end
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL bounce_release cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
            releases += int'(btn_release[0]);
        end
        checks++;
        if (releases != 1) begin
            errors++; $display("FAIL bounce_release_count got=%0d exp=1", releases);
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 38; k++) begin
            btn_raw[2] = (k < 2 * TD);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec || btn_level !== '0 || btn_press !== '0) begin
                errors++; $display("FAIL glitch cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic hold_button1(input string name, input int exp_presses);
        int presses = 0;
        int releases = 0;
        for (int k = 0; k < 92; k++) begin
            btn_raw[1] = (k < 62);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, dut_vec, exp_vec);
            end
            presses  += int'(btn_press[1]);
            releases += int'(btn_release[1]);
        end
        checks++;
        if (presses != exp_presses || releases != 1) begin
            errors++;
            $display("FAIL %s_counts press=%0d release=%0d exp press=%0d release=1",
                     name, presses, releases, exp_presses);
        end
    endtask

    task automatic test_auto_repeat();
        repeat_en = 7'b0000010;
        hold_button1("auto_repeat", 6);
    endtask

    task automatic test_repeat_disabled();
        int presses = 0;
        repeat_en = '0;
        hold_button1("repeat_off", 1);
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL repeat_hold_off cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
        end
        repeat_en[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL repeat_reenable cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
            presses += int'(btn_press[1]);
        end
        checks++;
        if (presses != 1) begin
            errors++; $display("FAIL repeat_reenable_pulse got=%0d exp=1", presses);
        end
        btn_raw[1] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL repeat_reenable_rel cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
        end
        repeat_en = '0;
    endtask

    task automatic test_switches();
        int chg = 0;
        sw_raw = 6'b101010;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL sw_change cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
            chg += int'(sw_changed);
        end
        checks++;
        if (chg != 1 || sw_level !== 6'b101010) begin
            errors++; $display("FAIL sw_result changed=%0d level=%b exp 1 101010", chg, sw_level);
        end
        sw_raw = 6'b010101;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL sw_reset_clear got=%h exp=0", dut_vec);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chg = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++; $display("FAIL sw_redebounce cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec);
            end
            chg += int'(sw_changed);
        end
        checks++;
        if (chg != 1 || sw_level !== 6'b010101) begin
            errors++; $display("FAIL sw_after_reset changed=%0d level=%b exp 1 010101", chg, sw_level);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 70; s++) begin
            int len = int'($urandom_range(60, 1));
            btn_raw = btn_raw ^ (NB'($urandom) & NB'($urandom));
            sw_raw  = sw_raw ^ (NS'($urandom) & NS'($urandom));
            if ($urandom_range(3, 0) == 0) repeat_en = NB'($urandom);
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++; $display("FAIL random seg=%0d cyc=%0d got=%h exp=%h", s, k, dut_vec, exp_vec);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_glitch();
        test_auto_repeat();
        test_repeat_disabled();
        test_switches();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
